// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl: keypad operand loader and MAC handshake sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int RES_W = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int DISP_W = (WIDTH > RES_W) ? WIDTH : RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              back,
  input  logic [WIDTH-1:0]  key_data,
  output logic [WIDTH-1:0]  mac_a,
  output logic [WIDTH-1:0]  mac_b,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  input  logic              mac_ready,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_data,
  output logic [DISP_W-1:0] disp_data,
  output logic              key_en,
  output logic [2:0]        state_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_A   = 3'd1,
    LOAD_B   = 3'd2,
    COMPUTE  = 3'd3,
    WAIT_RES = 3'd4,
    RESULT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                done_q, done_d;
  logic                step_q, back_q;

  logic [WIDTH-1:0]    bank_a_q [DEPTH];
  logic [WIDTH-1:0]    bank_b_q [DEPTH];

  logic                step_rise, back_rise;
  logic                addr_last;
  logic                wr_a, wr_b;

  assign step_rise = step & ~step_q;
  assign back_rise = back & ~back_q;
  assign addr_last = (addr_q == C_ADDR_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      step_q   <= 1'b0;
      back_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      done_q   <= done_d;
      step_q   <= step;
      back_q   <= back;
    end
  end

  // Operand storage deliberately survives reset so a reset does not wipe entered data.
  always_ff @(posedge clk) begin
    if (wr_a) bank_a_q[addr_q] <= key_data;
    if (wr_b) bank_b_q[addr_q] <= key_data;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    result_d  = result_q;
    done_d    = done_q;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    mac_valid = 1'b0;
    mac_first = 1'b0;
    mac_last  = 1'b0;
    key_en    = 1'b0;
    disp_data = '0;

    case (state_q)
      IDLE: begin
        if (step_rise) begin
          state_d = LOAD_A;
          addr_d  = '0;
        end
      end

      LOAD_A, LOAD_B: begin
        key_en    = 1'b1;
        disp_data = DISP_W'(key_data);
        // step has priority; a simultaneous back press is dropped.
        if (step_rise) begin
          wr_a = (state_q == LOAD_A);
          wr_b = (state_q == LOAD_B);
          if (addr_last) begin
            addr_d  = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : COMPUTE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else if (back_rise && (addr_q != '0)) begin
          addr_d = addr_q - ADDR_W'(1);
        end
      end

      COMPUTE: begin
        mac_valid = 1'b1;
        mac_first = (addr_q == '0);
        mac_last  = addr_last;
        if (mac_ready) begin
          if (addr_last) begin
            addr_d  = '0;
            state_d = WAIT_RES;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      WAIT_RES: begin
        if (res_valid) begin
          result_d = res_data;
          done_d   = 1'b1;
          state_d  = RESULT;
        end
      end

      RESULT: begin
        disp_data = DISP_W'(result_q);
        if (step_rise) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        addr_d  = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign mac_a     = bank_a_q[addr_q];
  assign mac_b     = bank_b_q[addr_q];
  assign state_out = state_q;
  assign addr_out  = addr_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl: directed table-driven bench for mac_seq_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic        back = 1'b0;
  logic [15:0] key_data = '0;
  logic [15:0] mac_a, mac_b;
  logic        mac_valid, mac_first, mac_last;
  logic        mac_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic [15:0] disp_data;
  logic        key_en;
  logic [2:0]  state_out;
  logic [2:0]  addr_out;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.WIDTH(16), .DEPTH(8), .RES_W(16)) dut (
    .clk(clk), .rst(rst), .step(step), .back(back), .key_data(key_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_first(mac_first),
    .mac_last(mac_last), .mac_ready(mac_ready), .res_valid(res_valid),
    .res_data(res_data), .disp_data(disp_data), .key_en(key_en),
    .state_out(state_out), .addr_out(addr_out), .done(done)
  );

  typedef struct {
    logic        s;
    logic        b;
    logic [15:0] key;
    logic [2:0]  st;
    logic [2:0]  ad;
  } vec_t;

  vec_t vq[$];

  function automatic void push(input logic s, input logic b, input logic [15:0] key,
                               input logic [2:0] st, input logic [2:0] ad);
    vec_t v;
    v.s = s; v.b = b; v.key = key; v.st = st; v.ad = ad;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] k);
    key_data = k;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    int cyc;
    int seen;
    logic [3:0] pat;
    logic [2:0] exp_st;

    // ---------------- table: IDLE -> LOAD_A with edits -> LOAD_B -> COMPUTE
    push(1, 0, 16'h0, 3'd1, 3'd0); push(0, 0, 16'h0, 3'd1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      push(1, 0, 16'(16'h1F00 + i), 3'd1, 3'(i + 1));
      push(0, 0, 16'(16'h1F00 + i), 3'd1, 3'(i + 1));
    end
    push(0, 1, 16'h0, 3'd1, 3'd2); push(0, 0, 16'h0, 3'd1, 3'd2);
    push(0, 1, 16'h0, 3'd1, 3'd1); push(0, 0, 16'h0, 3'd1, 3'd1);
    push(0, 1, 16'h0, 3'd1, 3'd0); push(0, 0, 16'h0, 3'd1, 3'd0);
    push(0, 1, 16'h0, 3'd1, 3'd0); push(0, 0, 16'h0, 3'd1, 3'd0);
    push(1, 0, 16'h1000, 3'd1, 3'd1); push(0, 0, 16'h1000, 3'd1, 3'd1);
    push(1, 0, 16'h1001, 3'd1, 3'd2); push(0, 0, 16'h1001, 3'd1, 3'd2);
    push(1, 1, 16'h1002, 3'd1, 3'd3); push(0, 0, 16'h1002, 3'd1, 3'd3);
    for (int i = 3; i < 7; i++) begin
      push(1, 0, 16'(16'h1000 + i), 3'd1, 3'(i + 1));
      push(0, 0, 16'(16'h1000 + i), 3'd1, 3'(i + 1));
    end
    push(1, 0, 16'h1007, 3'd2, 3'd0); push(0, 0, 16'h1007, 3'd2, 3'd0);
    push(1, 0, 16'h2000, 3'd2, 3'd1);
    for (int i = 0; i < 19; i++) push(1, 0, 16'h2000, 3'd2, 3'd1);
    push(0, 0, 16'h2000, 3'd2, 3'd1);
    for (int i = 1; i < 7; i++) begin
      push(1, 0, 16'(16'h2000 + i), 3'd2, 3'(i + 1));
      push(0, 0, 16'(16'h2000 + i), 3'd2, 3'(i + 1));
    end
    push(1, 0, 16'h2007, 3'd3, 3'd0); push(0, 0, 16'h2007, 3'd3, 3'd0);

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(mac_valid), 32'd0);
    chk("rst_key_en", 32'(key_en), 32'd0);
    chk("rst_disp", 32'(disp_data), 32'd0);
    rst = 1'b1;

    // ---------------- apply the table
    for (int i = 0; i < vq.size(); i++) begin
      step = vq[i].s;
      back = vq[i].b;
      key_data = vq[i].key;
      tick();
      exp_st = vq[i].st;
      chk($sformatf("tbl%0d_state", i), 32'(state_out), 32'(exp_st));
      chk($sformatf("tbl%0d_addr", i), 32'(addr_out), 32'(vq[i].ad));
      chk($sformatf("tbl%0d_key_en", i), 32'(key_en),
          32'((exp_st == 3'd1) || (exp_st == 3'd2)));
      chk($sformatf("tbl%0d_disp", i), 32'(disp_data),
          ((exp_st == 3'd1) || (exp_st == 3'd2)) ? 32'(vq[i].key) : 32'd0);
    end
    step = 1'b0;
    back = 1'b0;

    // ---------------- COMPUTE with ready pattern 1,0,0,1
    pat  = 4'b1001;
    hs   = 0;
    cyc  = 0;
    seen = 0;
    while (hs < 8 && cyc < 40) begin
      mac_ready = pat[3 - (cyc % 4)];
      #1;
      chk("cmp_state", 32'(state_out), 32'd3);
      chk("cmp_valid", 32'(mac_valid), 32'd1);
      chk("cmp_a", 32'(mac_a), 32'(16'h1000 + hs));
      chk("cmp_b", 32'(mac_b), 32'(16'h2000 + hs));
      chk("cmp_first", 32'(mac_first), 32'(hs == 0));
      chk("cmp_last", 32'(mac_last), 32'(hs == 7));
      chk("cmp_disp", 32'(disp_data), 32'd0);
      if (mac_valid && mac_ready) seen++;
      if (mac_ready) hs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    mac_ready = 1'b0;
    chk("cmp_handshakes", 32'(seen), 32'd8);
    chk("cmp_to_wait_state", 32'(state_out), 32'd4);
    chk("cmp_to_wait_valid", 32'(mac_valid), 32'd0);
    chk("cmp_to_wait_addr", 32'(addr_out), 32'd0);

    // ---------------- WAIT_RES ignores buttons
    press(16'h0);
    back = 1'b1; tick(); back = 1'b0; tick();
    chk("wait_ignore_state", 32'(state_out), 32'd4);
    chk("wait_done", 32'(done), 32'd0);

    res_data = 16'hBEEF;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("res_state", 32'(state_out), 32'd5);
    chk("res_done", 32'(done), 32'd1);
    chk("res_disp", 32'(disp_data), 32'h0000BEEF);

    // spurious result in RESULT
    res_data = 16'h1234;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("spur_res_state", 32'(state_out), 32'd5);
    chk("spur_res_disp", 32'(disp_data), 32'h0000BEEF);

    press(16'h0);
    chk("restart_state", 32'(state_out), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_disp", 32'(disp_data), 32'd0);

    // spurious result in IDLE
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("spur_idle_state", 32'(state_out), 32'd0);
    chk("spur_idle_done", 32'(done), 32'd0);

    // ---------------- reset mid-COMPUTE
    press(16'h0);
    for (int i = 0; i < 16; i++) press(16'(16'h3000 + i));
    chk("rl_state", 32'(state_out), 32'd3);
    mac_ready = 1'b1;
    tick();
    mac_ready = 1'b0;
    chk("rl_addr", 32'(addr_out), 32'd1);
    chk("rl_a", 32'(mac_a), 32'h00003001);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(mac_valid), 32'd0);
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_addr", 32'(addr_out), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    press(16'h0);
    chk("post_rst_state", 32'(state_out), 32'd1);
    chk("post_rst_addr", 32'(addr_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Clocked controller for the MAC datapath. Loads two operand vectors A and B from the keypad into internal storage, one entry per step press.
- Streams the A/B pairs to an external MAC unit over a valid/ready handshake, then captures the MAC result and holds it for display.
- Generalised in WIDTH and DEPTH. Adds back-step editing, a handshake-driven compute phase and a result hold/restart.

Parameters:
WIDTH, 16, operand width in bits
DEPTH, 8, entries per operand bank (must be >= 2)
RES_W, 16, MAC result width in bits
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
clk  in  1  system clock
rst  in  1  reset
step  in  1  debounced, synchronous advance button (level)
back  in  1  debounced, synchronous back button (level)
key_data  in  WIDTH  current keypad value
mac_a  out  WIDTH  operand A to MAC
mac_b  out  WIDTH  operand B to MAC
mac_valid  out  1  operand pair valid
mac_first  out  1  first pair of vector (qualifies mac_valid)
mac_last  out  1  last pair of vector (qualifies mac_valid)
mac_ready  in  1  MAC accepts pair
res_valid  in  1  MAC result valid (single-cycle pulse)
res_data  in  RES_W  MAC result
disp_data  out  max(WIDTH,RES_W)  value for hex display, zero-extended
key_en  out  1  keypad scanning enable
state_out  out  3  current state encoding
addr_out  out  ADDR_W  current address
done  out  1  result held

Behaviour:
- rst: asynchronous, active-low. While low: state=IDLE, addr=0, result reg=0, done=0, edge-detect regs=0.
- Outputs while rst is low: mac_valid=0, key_en=0, disp_data=0, state_out=0. Operand storage is not cleared.
- Reset mid-operation from any state returns to IDLE; mac_valid drops without waiting for a clock edge.
- Edge detect: step_rise = step & ~step_q, with step_q registered every clk; back is handled the same way.
- Each rising edge is one action. A held button causes no repeats.
- step_rise and back_rise in the same cycle: step wins, back is ignored.
- State encoding: IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, WAIT_RES=4, RESULT=5.
- IDLE:
  - disp_data=0.
  - step_rise -> LOAD_A, addr=0.
- LOAD_A / LOAD_B:
  - key_en=1; disp_data=key_data (live).
  - step_rise writes key_data to bank[addr] at that clk.
  - If addr==DEPTH-1: addr<=0 and advance (LOAD_A->LOAD_B, LOAD_B->COMPUTE). Otherwise addr<=addr+1.
  - back_rise: addr<=addr-1 if addr>0, else hold. No write, no state change; back does not cross the bank boundary.
- COMPUTE:
  - mac_valid=1, mac_a=A[addr], mac_b=B[addr], mac_first=(addr==0), mac_last=(addr==DEPTH-1).
  - Outputs stay stable until mac_valid&mac_ready.
  - On handshake: if last -> WAIT_RES, addr<=0; else addr<=addr+1.
  - disp_data=0. step and back are ignored.
- WAIT_RES:
  - mac_valid=0.
  - On res_valid: result reg<=res_data, done<=1, -> RESULT.
  - step and back are ignored. res_valid in any other state is ignored.
- RESULT:
  - disp_data=result reg, done=1.
  - step_rise -> IDLE, done<=0. Result reg is held until the next capture.
- Throughput: one pair per clk when mac_ready is held high. COMPUTE lasts exactly DEPTH cycles with ready=1.
- state_out and addr_out reflect the registered state and address directly.

Test Plan:
- Reset mid-COMPUTE (rst low for 1 cycle) -> mac_valid=0 immediately, state_out=0, addr_out=0, done=0; then step -> state 1.
- From IDLE, 8 step pulses with key_data=16'h1000+i, then 8 with 16'h2000+i -> state_out=3 on the 17th pulse's clk. A[i] and B[i] are checked via mac_a/mac_b during compute.
- In LOAD_A at addr=3: back -> addr 2. back at addr=0 -> addr stays 0. step and back together at addr 2 -> write, addr 3. Re-entered value overwrites the earlier one, checked at compute.
- COMPUTE with mac_ready toggled 1,0,0,1,...: pairs are held stable while ready=0. Exactly 8 handshakes occur, mac_first only on pair 0, mac_last only on pair 7, then state 4.
- WAIT_RES: res_valid with res_data=16'hBEEF -> state 5, done=1, disp_data=16'hBEEF. A spurious res_valid in RESULT/IDLE causes no change. step -> IDLE, done=0.
- step held high for 20 cycles in LOAD_B -> exactly one write and one increment.
